// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Brief    : RV32I decode: register file, immediates, load-use stall, ID/EX.
// Revision : 1.0
// ============================================================================
module decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h00007FFC,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     ir,
    input  logic [31:0]     npc,
    input  logic            branch_sig,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            stall_f,
    output logic            stall_d,
    output logic            ex_valid,
    output logic [31:0]     ex_pc,
    output logic [XLEN-1:0] ex_rs1_val,
    output logic [XLEN-1:0] ex_rs2_val,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [6:0]      ex_opcode,
    output logic [2:0]      ex_funct3,
    output logic            ex_funct7b5,
    output logic            ex_is_load,
    output logic            ex_is_store,
    output logic            ex_reg_write,
    output logic            ex_illegal
);

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;

    logic [XLEN-1:0] r_regs [32];
    logic            r_dvalid;

    logic            r_ex_valid;
    logic [31:0]     r_ex_pc;
    logic [XLEN-1:0] r_ex_rs1_val;
    logic [XLEN-1:0] r_ex_rs2_val;
    logic [XLEN-1:0] r_ex_imm;
    logic [4:0]      r_ex_rs1;
    logic [4:0]      r_ex_rs2;
    logic [4:0]      r_ex_rd;
    logic [6:0]      r_ex_opcode;
    logic [2:0]      r_ex_funct3;
    logic            r_ex_funct7b5;
    logic            r_ex_is_load;
    logic            r_ex_is_store;
    logic            r_ex_reg_write;
    logic            r_ex_illegal;

    logic [6:0]      w_opcode;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [4:0]      w_rd;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic [XLEN-1:0] w_imm;
    logic            w_legal;
    logic            w_use_rs1;
    logic            w_use_rs2;
    logic            w_writes_rd;
    logic            w_is_load;
    logic            w_is_store;
    logic            w_hz;

    assign w_opcode = ir[6:0];
    assign w_rs1    = ir[19:15];
    assign w_rs2    = ir[24:20];
    assign w_rd     = ir[11:7];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_we && (wb_rd != 5'd0)) begin
            r_regs[wb_rd] <= wb_data;
        end
    end

    // Write-through: a register being written back this cycle reads the new value.
    assign w_rs1_val = (w_rs1 == 5'd0)                 ? '0      :
                       (wb_we && (wb_rd == w_rs1))     ? wb_data : r_regs[w_rs1];
    assign w_rs2_val = (w_rs2 == 5'd0)                 ? '0      :
                       (wb_we && (wb_rd == w_rs2))     ? wb_data : r_regs[w_rs2];

    always_comb begin
        w_imm       = '0;
        w_legal     = 1'b1;
        w_use_rs1   = 1'b1;
        w_use_rs2   = 1'b0;
        w_writes_rd = 1'b0;
        w_is_load   = 1'b0;
        w_is_store  = 1'b0;
        case (w_opcode)
            c_OP_LOAD: begin
                w_imm       = {{20{ir[31]}}, ir[31:20]};
                w_writes_rd = 1'b1;
                w_is_load   = 1'b1;
            end
            c_OP_IMM, c_OP_JALR: begin
                w_imm       = {{20{ir[31]}}, ir[31:20]};
                w_writes_rd = 1'b1;
            end
            c_OP_STORE: begin
                w_imm      = {{20{ir[31]}}, ir[31:25], ir[11:7]};
                w_use_rs2  = 1'b1;
                w_is_store = 1'b1;
            end
            c_OP_BRANCH: begin
                w_imm     = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
                w_use_rs2 = 1'b1;
            end
            c_OP_LUI, c_OP_AUIPC: begin
                w_imm       = {ir[31:12], 12'b0};
                w_use_rs1   = 1'b0;
                w_writes_rd = 1'b1;
            end
            c_OP_JAL: begin
                w_imm       = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
                w_use_rs1   = 1'b0;
                w_writes_rd = 1'b1;
            end
            c_OP_REG: begin
                w_use_rs2   = 1'b1;
                w_writes_rd = 1'b1;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    assign w_hz = r_ex_valid && r_ex_is_load && (r_ex_rd != 5'd0) && r_dvalid &&
                  ((w_use_rs1 && (w_rs1 == r_ex_rd)) || (w_use_rs2 && (w_rs2 == r_ex_rd)));

    // A taken branch discards the decode slot, so it must not freeze fetch.
    assign stall_f = w_hz && !branch_sig;
    assign stall_d = w_hz && !branch_sig;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dvalid <= 1'b0;
        end else begin
            r_dvalid <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ex_valid     <= 1'b0;
            r_ex_pc        <= RESET_PC;
            r_ex_rs1_val   <= '0;
            r_ex_rs2_val   <= '0;
            r_ex_imm       <= '0;
            r_ex_rs1       <= '0;
            r_ex_rs2       <= '0;
            r_ex_rd        <= '0;
            r_ex_opcode    <= '0;
            r_ex_funct3    <= '0;
            r_ex_funct7b5  <= 1'b0;
            r_ex_is_load   <= 1'b0;
            r_ex_is_store  <= 1'b0;
            r_ex_reg_write <= 1'b0;
            r_ex_illegal   <= 1'b0;
        end else if (branch_sig || w_hz) begin
            r_ex_valid     <= 1'b0;
            r_ex_is_load   <= 1'b0;
            r_ex_is_store  <= 1'b0;
            r_ex_reg_write <= 1'b0;
            r_ex_illegal   <= 1'b0;
        end else begin
            r_ex_valid     <= r_dvalid;
            r_ex_pc        <= npc;
            r_ex_rs1_val   <= w_rs1_val;
            r_ex_rs2_val   <= w_rs2_val;
            r_ex_imm       <= w_imm;
            r_ex_rs1       <= w_rs1;
            r_ex_rs2       <= w_rs2;
            r_ex_rd        <= w_rd;
            r_ex_opcode    <= w_opcode;
            r_ex_funct3    <= ir[14:12];
            r_ex_funct7b5  <= ir[30];
            r_ex_is_load   <= r_dvalid && w_is_load;
            r_ex_is_store  <= r_dvalid && w_is_store;
            r_ex_reg_write <= r_dvalid && w_writes_rd && (w_rd != 5'd0);
            r_ex_illegal   <= r_dvalid && !w_legal;
        end
    end

    assign ex_valid     = r_ex_valid;
    assign ex_pc        = r_ex_pc;
    assign ex_rs1_val   = r_ex_rs1_val;
    assign ex_rs2_val   = r_ex_rs2_val;
    assign ex_imm       = r_ex_imm;
    assign ex_rs1       = r_ex_rs1;
    assign ex_rs2       = r_ex_rs2;
    assign ex_rd        = r_ex_rd;
    assign ex_opcode    = r_ex_opcode;
    assign ex_funct3    = r_ex_funct3;
    assign ex_funct7b5  = r_ex_funct7b5;
    assign ex_is_load   = r_ex_is_load;
    assign ex_is_store  = r_ex_is_store;
    assign ex_reg_write = r_ex_reg_write;
    assign ex_illegal   = r_ex_illegal;

endmodule
`default_nettype wire
